// File: rtl/line_window_3x3.sv
// line_window_3x3
//
// Upstream stage of the Gaussian smoothing filter. Takes a raster-order pixel
// stream, buffers the two previous image lines in asynchronous-read RAMs and
// presents a registered 3x3 neighbourhood. o_valid pulses for one cycle only
// when all nine window pixels belong to the current frame (interior centres).
//
// Ports:
//   clk                         rising-edge system clock
//   reset                       synchronous, active-high reset
//   i_valid                     pixel accepted this cycle (no backpressure)
//   i_sof                       with i_valid: current pixel is frame pixel (0,0)
//   i_pixel                     incoming pixel, treated as opaque
//   PixelData_00..PixelData_22  window, row r (0 = oldest line), column c
//                               (0 = oldest column); PixelData_11 is the centre
//   o_valid                     window valid, one-cycle pulse per window
//   o_cx, o_cy                  window centre column / row
//
// Optional feature (macro LINE_WINDOW_COORD_EN):
//   defined   - o_cx/o_cy register the centre coordinate alongside o_valid and
//               hold between valids
//   undefined - o_cx/o_cy are tied to 0 and no coordinate registers exist

module line_window_3x3 #(
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned IMG_HEIGHT = 240,
  parameter int unsigned DATA_WIDTH = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_valid,
  input  logic                          i_sof,
  input  logic [DATA_WIDTH-1:0]         i_pixel,
  output logic [DATA_WIDTH-1:0]         PixelData_00,
  output logic [DATA_WIDTH-1:0]         PixelData_01,
  output logic [DATA_WIDTH-1:0]         PixelData_02,
  output logic [DATA_WIDTH-1:0]         PixelData_10,
  output logic [DATA_WIDTH-1:0]         PixelData_11,
  output logic [DATA_WIDTH-1:0]         PixelData_12,
  output logic [DATA_WIDTH-1:0]         PixelData_20,
  output logic [DATA_WIDTH-1:0]         PixelData_21,
  output logic [DATA_WIDTH-1:0]         PixelData_22,
  output logic                          o_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]  o_cx,
  output logic [$clog2(IMG_HEIGHT)-1:0] o_cy
);

  localparam int unsigned XW = $clog2(IMG_WIDTH);
  localparam int unsigned YW = $clog2(IMG_HEIGHT);

  localparam logic [XW-1:0] XLast = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] YLast = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] XTwo  = XW'(2);
  localparam logic [YW-1:0] YTwo  = YW'(2);

  // Position counters: point at the position the next accepted pixel takes.
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;

  // Position of the pixel on i_pixel this cycle, and its raster successor.
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic [XW-1:0] nxt_x;
  logic [YW-1:0] nxt_y;
  logic          interior;

  // Line buffers: lb1 holds row y-1, lb2 holds row y-2. Not reset; stale
  // contents never reach a valid window because of the interior gating.
  logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb2 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb_a;
  logic [DATA_WIDTH-1:0] lb_b;

  always_comb begin
    cur_x = i_sof ? '0 : x_cnt;
    cur_y = i_sof ? '0 : y_cnt;
    nxt_x = cur_x + XW'(1);
    nxt_y = cur_y;
    if (cur_x == XLast) begin
      nxt_x = '0;
      nxt_y = (cur_y == YLast) ? '0 : cur_y + YW'(1);
    end
    // Windows straddling a row wrap or touching rows 0-1 are suppressed.
    interior = (cur_x >= XTwo) && (cur_y >= YTwo);
  end

  assign lb_a = lb2[cur_x];
  assign lb_b = lb1[cur_x];

  always_ff @(posedge clk) begin
    if (reset) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (i_valid) begin
      x_cnt <= nxt_x;
      y_cnt <= nxt_y;
    end
  end

  // Column x of lb1 ages into lb2 as the new pixel takes its place.
  always_ff @(posedge clk) begin
    if (i_valid) begin
      lb2[cur_x] <= lb_b;
      lb1[cur_x] <= i_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      PixelData_00 <= '0;
      PixelData_01 <= '0;
      PixelData_02 <= '0;
      PixelData_10 <= '0;
      PixelData_11 <= '0;
      PixelData_12 <= '0;
      PixelData_20 <= '0;
      PixelData_21 <= '0;
      PixelData_22 <= '0;
      o_valid      <= 1'b0;
    end else begin
      o_valid <= i_valid && interior;
      if (i_valid) begin
        PixelData_00 <= PixelData_01;
        PixelData_01 <= PixelData_02;
        PixelData_02 <= lb_a;
        PixelData_10 <= PixelData_11;
        PixelData_11 <= PixelData_12;
        PixelData_12 <= lb_b;
        PixelData_20 <= PixelData_21;
        PixelData_21 <= PixelData_22;
        PixelData_22 <= i_pixel;
      end
    end
  end

`ifdef LINE_WINDOW_COORD_EN
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;

  // Centre is one column and one row behind the pixel that completes the window.
  always_ff @(posedge clk) begin
    if (reset) begin
      cx <= '0;
      cy <= '0;
    end else if (i_valid && interior) begin
      cx <= cur_x - XW'(1);
      cy <= cur_y - YW'(1);
    end
  end

  assign o_cx = cx;
  assign o_cy = cy;
`else
  assign o_cx = '0;
  assign o_cy = '0;
`endif

endmodule
